// File: rtl/mac_dot_seq_if.sv
// Operand stream and MAC pipeline issue/return signals for mac_dot_seq.
// Signal names are from the sequencer's point of view; the sequencer connects as slave.
interface mac_dot_seq_if #(
  parameter int unsigned TRANS_ID_BITS = 4
);
  logic                     op_valid_i;
  logic [31:0]              op_a_i;
  logic [31:0]              op_b_i;
  logic                     op_ready_o;
  logic                     mac_valid_o;
  logic [31:0]              mac_a_o;
  logic [31:0]              mac_b_o;
  logic [TRANS_ID_BITS-1:0] mac_trans_id_o;
  logic                     mac_valid_i;
  logic [31:0]              mac_result_i;
  logic [TRANS_ID_BITS-1:0] mac_trans_id_i;

  modport slave (
    input  op_valid_i, op_a_i, op_b_i, mac_valid_i, mac_result_i, mac_trans_id_i,
    output op_ready_o, mac_valid_o, mac_a_o, mac_b_o, mac_trans_id_o
  );

  modport master (
    output op_valid_i, op_a_i, op_b_i, mac_valid_i, mac_result_i, mac_trans_id_i,
    input  op_ready_o, mac_valid_o, mac_a_o, mac_b_o, mac_trans_id_o
  );
endinterface

// File: rtl/mac_dot_seq.sv
// Dot-product job sequencer: issues operand pairs to an external MAC pipeline and
// accumulates the tagged partial sums it returns into one 32-bit result per job.
module mac_dot_seq #(
  parameter int unsigned LEN_W         = 8,
  parameter int unsigned TRANS_ID_BITS = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     start_i,
  input  logic [LEN_W-1:0]         len_i,
  input  logic [TRANS_ID_BITS-1:0] trans_id_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [31:0]              result_o,
  output logic [TRANS_ID_BITS-1:0] trans_id_o,
  output logic                     stray_o,
  mac_dot_seq_if.slave             bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e                   state_q, state_d;
  logic [LEN_W-1:0]         len_q, len_d;
  logic [TRANS_ID_BITS-1:0] tag_q, tag_d;
  logic [31:0]              acc_q, acc_d;
  logic [LEN_W-1:0]         iss_q, iss_d;
  logic [LEN_W-1:0]         ret_q, ret_d;
  logic [31:0]              result_q;
  logic [TRANS_ID_BITS-1:0] trans_q;
  logic                     stray_q;

  logic op_ready;
  logic issue;
  logic accept;

  assign op_ready = (state_q == StRun);
  assign issue    = bus.op_valid_i & op_ready;
  assign accept   = bus.mac_valid_i & ((state_q == StRun) | (state_q == StDrain)) &
                    (bus.mac_trans_id_i == tag_q);

  assign bus.op_ready_o     = op_ready;
  assign bus.mac_valid_o    = issue & ~flush_i;
  assign bus.mac_a_o        = bus.op_a_i;
  assign bus.mac_b_o        = bus.op_b_i;
  assign bus.mac_trans_id_o = tag_q;

  assign busy_o     = (state_q != StIdle);
  assign done_o     = (state_q == StDone);
  assign result_o   = result_q;
  assign trans_id_o = trans_q;
  assign stray_o    = stray_q;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    tag_d   = tag_q;
    acc_d   = acc_q;
    iss_d   = iss_q;
    ret_d   = ret_q;

    if (accept) begin
      acc_d = acc_q + bus.mac_result_i;
      ret_d = ret_q + LEN_W'(1);
    end
    if (issue) begin
      iss_d = iss_q + LEN_W'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (start_i && !flush_i) begin
          len_d   = len_i;
          tag_d   = trans_id_i;
          acc_d   = '0;
          iss_d   = '0;
          ret_d   = '0;
          state_d = (len_i != '0) ? StRun : StDone;
        end
      end
      StRun: begin
        // Last issue may coincide with last return; skip DRAIN in that case.
        if (issue && (iss_d == len_q)) begin
          state_d = (ret_d == len_q) ? StDone : StDrain;
        end
      end
      StDrain: begin
        if (ret_d == len_q) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (flush_i) begin
      state_d = StIdle;
      acc_d   = '0;
      iss_d   = '0;
      ret_d   = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= StIdle;
      len_q    <= '0;
      tag_q    <= '0;
      acc_q    <= '0;
      iss_q    <= '0;
      ret_q    <= '0;
      result_q <= '0;
      trans_q  <= '0;
      stray_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      tag_q   <= tag_d;
      acc_q   <= acc_d;
      iss_q   <= iss_d;
      ret_q   <= ret_d;
      stray_q <= bus.mac_valid_i & ~accept;
      // Result registers load on entry to DONE and hold until the next job completes.
      if (state_d == StDone) begin
        result_q <= acc_d;
        trans_q  <= tag_d;
      end
    end
  end

endmodule
